axil_2_wb: RTL and testbench
============================

Name: axil_2_wb

Overview:
- AXI4-Lite responder that converts single-beat AXI-Lite reads and writes into classic Wishbone master cycles.
- Opposite direction of the Wishbone-to-AXI bridge in front of the FIR: here an AXI-Lite initiator (e.g. a test DMA or the FIR-side controller) reaches Wishbone-mapped user registers.
- One transaction in flight at a time.
- Per-transaction timeout; an unacknowledged Wishbone cycle returns SLVERR.

Parameters:
- pADDR_WIDTH, 12, AXI-Lite address width. Offset bits forwarded to Wishbone.
- pDATA_WIDTH, 32, data width for both sides.
- pBASE_ADDR, 32'h3600_0000, Wishbone base address. Upper bits are ORed above the AXI offset.
- pTIMEOUT, 255, cycles to wait for wbm_ack_i before aborting. Must be at least 1.

Ports:
- wbs_clk_i  in  1  clock.
- wbs_rst_i  in  1  synchronous active-high reset.
- awvalid  in  1  write-address valid.
- awready  out  1  write-address ready.
- awaddr  in  pADDR_WIDTH  write address.
- wvalid  in  1  write-data valid.
- wready  out  1  write-data ready.
- wdata  in  pDATA_WIDTH  write data.
- wstrb  in  pDATA_WIDTH/8  byte strobes.
- bvalid  out  1  write-response valid.
- bready  in  1  write-response ready.
- bresp  out  2  2'b00 OKAY / 2'b10 SLVERR.
- arvalid  in  1  read-address valid.
- arready  out  1  read-address ready.
- araddr  in  pADDR_WIDTH  read address.
- rvalid  out  1  read-data valid.
- rready  in  1  read-data ready.
- rdata  out  pDATA_WIDTH  read data.
- rresp  out  2  read response.
- wbm_cyc_o  out  1  Wishbone cycle.
- wbm_stb_o  out  1  Wishbone strobe.
- wbm_we_o  out  1  Wishbone write enable.
- wbm_adr_o  out  32  pBASE_ADDR | {20'b0, offset}.
- wbm_dat_o  out  pDATA_WIDTH  write data.
- wbm_sel_o  out  pDATA_WIDTH/8  byte select; equals wstrb on writes, all ones on reads.
- wbm_ack_i  in  1  Wishbone acknowledge.
- wbm_dat_i  in  pDATA_WIDTH  Wishbone read data.

Behaviour:
- Reset: all outputs 0, state IDLE, aw_held=w_held=0, last_served=READ, timeout counter 0.
- Reset mid-transaction abandons it immediately: cyc/stb drop in the cycle after reset is sampled, and no response is issued.
- All outputs are registered. The ready signals are combinational only from internal state, never from the same-cycle valid.

Write capture:
- In IDLE, awready = !aw_held and wready = !w_held.
- AW and W are accepted independently, in either order or together. Each handshake latches its address, data and strobe.
- A write is pending when aw_held && w_held.

Arbitration (evaluated in IDLE):
- Read request: arvalid=1 with arready=1. arready is high in IDLE unless a write is pending and was picked this cycle.
- Write pending and arvalid both present: serve the opposite of last_served. The first conflict after reset therefore goes to the write.
- The loser waits; its ready stays low and its held data is kept.

States:
- IDLE -> WB_WR (write pending and selected): cyc=stb=we=1 from the next cycle, with adr/dat/sel taken from the latches.
- IDLE -> WB_RD (AR accepted): araddr latched, cyc=stb=1, we=0, sel=all ones.
- WB_WR/WB_RD on wbm_ack_i=1:
  - Drop cyc/stb the next cycle.
  - Capture wbm_dat_i on reads.
  - resp = OKAY.
  - Go to WR_RESP or RD_RESP.
  - Counting the AR/AW+W handshake as cycle 0: with ack in cycle 1, bvalid/rvalid rise in cycle 2.
- Timeout: the counter increments each cycle stb is high without ack. When it reaches pTIMEOUT, drop cyc/stb, resp = SLVERR, rdata = 0, go to the RESP state.
- An ack arriving in the same cycle the counter reaches pTIMEOUT counts as success (ack wins).
- WR_RESP: bvalid=1 until bready. On handshake: clear aw_held/w_held, set last_served=WRITE, go to IDLE.
- RD_RESP: rvalid=1, rdata/rresp held stable until rready. On handshake: last_served=READ, go to IDLE.
- AW/W presented during WB_*/RESP states are not accepted: awready=wready=0 outside IDLE.
- An ack while cyc is low is ignored.

Test Plan:
- Write awaddr=0x010, wdata=0x0000_0040, wstrb=0xF; slave acks after 2 cycles -> wbm_adr_o=0x3600_0010, wbm_dat_o=0x40, wbm_sel_o=0xF, we=1. Then bresp=00, single bvalid pulse held until bready.
- W presented 3 cycles before AW (wdata=0xA5A5_A5A5, wstrb=0x3) -> no Wishbone cycle until AW arrives. Then wbm_sel_o=0x3, wbm_dat_o=0xA5A5_A5A5.
- Read araddr=0x084, slave returns 0x1234_5678 with ack in cycle 1 -> rvalid in cycle 2, rdata=0x1234_5678, rresp=00. rready held low 4 cycles -> rdata stays stable.
- Write pending and arvalid asserted in the same IDLE cycle, twice back-to-back -> first write then read, then next conflict read then write. No overlapping Wishbone cycles.
- Slave never acks, pTIMEOUT=8 -> cyc/stb high exactly 8 cycles then drop. rresp=10, rdata=0; the next read with ack succeeds with OKAY.
- wbs_rst_i asserted during WB_RD stb -> cyc/stb=0 next cycle, no rvalid, arready=1 after reset release.

Source files
------------

// File: rtl/axil_2_wb.sv
// AXI4-Lite responder bridging single-beat reads/writes onto a classic Wishbone master.
// One transaction in flight; an unacknowledged Wishbone cycle times out with SLVERR.
module axil_2_wb #(
    parameter int          pADDR_WIDTH = 12,
    parameter int          pDATA_WIDTH = 32,
    parameter logic [31:0] pBASE_ADDR  = 32'h3600_0000,
    parameter int          pTIMEOUT    = 255
) (
    input  logic                     wbs_clk_i,
    input  logic                     wbs_rst_i,
    input  logic                     awvalid,
    output logic                     awready,
    input  logic [pADDR_WIDTH-1:0]   awaddr,
    input  logic                     wvalid,
    output logic                     wready,
    input  logic [pDATA_WIDTH-1:0]   wdata,
    input  logic [pDATA_WIDTH/8-1:0] wstrb,
    output logic                     bvalid,
    input  logic                     bready,
    output logic [1:0]               bresp,
    input  logic                     arvalid,
    output logic                     arready,
    input  logic [pADDR_WIDTH-1:0]   araddr,
    output logic                     rvalid,
    input  logic                     rready,
    output logic [pDATA_WIDTH-1:0]   rdata,
    output logic [1:0]               rresp,
    output logic                     wbm_cyc_o,
    output logic                     wbm_stb_o,
    output logic                     wbm_we_o,
    output logic [31:0]              wbm_adr_o,
    output logic [pDATA_WIDTH-1:0]   wbm_dat_o,
    output logic [pDATA_WIDTH/8-1:0] wbm_sel_o,
    input  logic                     wbm_ack_i,
    input  logic [pDATA_WIDTH-1:0]   wbm_dat_i
);

    localparam int SW = pDATA_WIDTH / 8;
    localparam int CW = $clog2(pTIMEOUT + 1);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE, ST_WB_WR, ST_WB_RD, ST_WR_RESP, ST_RD_RESP
    } state_t;

    state_t state_q, state_d;

    logic                   aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic [pADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
    logic [pDATA_WIDTH-1:0] w_data_q, w_data_d;
    logic [SW-1:0]          w_strb_q, w_strb_d;
    logic                   last_wr_q, last_wr_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
    logic [31:0]            adr_q, adr_d;
    logic [pDATA_WIDTH-1:0] dat_o_q, dat_o_d;
    logic [SW-1:0]          sel_q, sel_d;
    logic                   bvalid_q, bvalid_d, rvalid_q, rvalid_d;
    logic [1:0]             bresp_q, bresp_d, rresp_q, rresp_d;
    logic [pDATA_WIDTH-1:0] rdata_q, rdata_d;

    logic          idle, wr_pend, aw_hs, w_hs, ar_hs, in_wb, timed_out;
    logic [CW-1:0] cnt_inc;

    function automatic logic [31:0] wb_adr(input logic [pADDR_WIDTH-1:0] off);
        return pBASE_ADDR | 32'(off);
    endfunction

    // Readies depend only on state, never on the same-cycle valids.
    assign idle      = (state_q == ST_IDLE) && !wbs_rst_i;
    assign wr_pend   = aw_held_q && w_held_q;
    assign awready   = idle && !aw_held_q;
    assign wready    = idle && !w_held_q;
    assign arready   = idle && !(wr_pend && !last_wr_q);
    assign aw_hs     = awvalid && awready;
    assign w_hs      = wvalid && wready;
    assign ar_hs     = arvalid && arready;
    assign in_wb     = (state_q == ST_WB_WR) || (state_q == ST_WB_RD);
    assign cnt_inc   = cnt_q + CW'(1);
    assign timed_out = (cnt_inc == CW'(pTIMEOUT));

    always_ff @(posedge wbs_clk_i) begin
        if (wbs_rst_i) begin
            state_q   <= ST_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            last_wr_q <= 1'b0;
            cnt_q     <= '0;
            cyc_q     <= 1'b0;
            stb_q     <= 1'b0;
            we_q      <= 1'b0;
            adr_q     <= '0;
            dat_o_q   <= '0;
            sel_q     <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= '0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= '0;
        end else begin
            state_q   <= state_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            aw_addr_q <= aw_addr_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            last_wr_q <= last_wr_d;
            cnt_q     <= cnt_d;
            cyc_q     <= cyc_d;
            stb_q     <= stb_d;
            we_q      <= we_d;
            adr_q     <= adr_d;
            dat_o_q   <= dat_o_d;
            sel_q     <= sel_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    // A held write loses to AR only when the last served transaction was a write.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (ar_hs)        state_d = ST_WB_RD;
                else if (wr_pend) state_d = ST_WB_WR;
            end
            ST_WB_WR:   if (wbm_ack_i || timed_out) state_d = ST_WR_RESP;
            ST_WB_RD:   if (wbm_ack_i || timed_out) state_d = ST_RD_RESP;
            ST_WR_RESP: if (bready) state_d = ST_IDLE;
            ST_RD_RESP: if (rready) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        aw_addr_d = aw_addr_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        last_wr_d = last_wr_q;
        adr_d     = adr_q;
        dat_o_d   = dat_o_q;
        sel_d     = sel_q;
        bresp_d   = bresp_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        cnt_d     = '0;

        if (aw_hs) begin
            aw_held_d = 1'b1;
            aw_addr_d = awaddr;
        end
        if (w_hs) begin
            w_held_d = 1'b1;
            w_data_d = wdata;
            w_strb_d = wstrb;
        end
        if (in_wb && !wbm_ack_i && !timed_out) cnt_d = cnt_inc;

        unique case (state_q)
            ST_IDLE: begin
                if (state_d == ST_WB_RD) begin
                    adr_d = wb_adr(araddr);
                    sel_d = '1;
                end else if (state_d == ST_WB_WR) begin
                    adr_d   = wb_adr(aw_addr_q);
                    dat_o_d = w_data_q;
                    sel_d   = w_strb_q;
                end
            end
            ST_WB_WR: begin
                if (wbm_ack_i)      bresp_d = RESP_OKAY;
                else if (timed_out) bresp_d = RESP_SLVERR;
            end
            ST_WB_RD: begin
                if (wbm_ack_i) begin
                    rdata_d = wbm_dat_i;
                    rresp_d = RESP_OKAY;
                end else if (timed_out) begin
                    rdata_d = '0;
                    rresp_d = RESP_SLVERR;
                end
            end
            ST_WR_RESP: begin
                if (bready) begin
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    last_wr_d = 1'b1;
                end
            end
            ST_RD_RESP: if (rready) last_wr_d = 1'b0;
            default: ;
        endcase

        cyc_d    = (state_d == ST_WB_WR) || (state_d == ST_WB_RD);
        stb_d    = cyc_d;
        we_d     = (state_d == ST_WB_WR);
        bvalid_d = (state_d == ST_WR_RESP);
        rvalid_d = (state_d == ST_RD_RESP);
    end

    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = stb_q;
    assign wbm_we_o  = we_q;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_o_q;
    assign wbm_sel_o = sel_q;
    assign bvalid    = bvalid_q;
    assign bresp     = bresp_q;
    assign rvalid    = rvalid_q;
    assign rdata     = rdata_q;
    assign rresp     = rresp_q;

endmodule

// File: tb/tb_axil_2_wb.sv
// Directed bench for axil_2_wb: per-cycle vector table for a basic write and read,
// then hand sequences for W-before-AW, arbitration, timeout and mid-cycle reset.
module tb_axil_2_wb;

    logic        wbs_clk_i = 1'b0;
    logic        wbs_rst_i;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [11:0] awaddr, araddr;
    logic [31:0] wdata, rdata, wbm_adr_o, wbm_dat_o, wbm_dat_i;
    logic [3:0]  wstrb, wbm_sel_o;
    logic [1:0]  bresp, rresp;
    logic        arvalid, arready, rvalid, rready;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;

    axil_2_wb #(.pTIMEOUT(8)) dut (
        .wbs_clk_i(wbs_clk_i), .wbs_rst_i(wbs_rst_i),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
        .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i)
    );

    always #5 wbs_clk_i = ~wbs_clk_i;

    int checks = 0;
    int errors = 0;

    // ctl = {awvalid,wvalid,arvalid,bready,rready,ack}
    // eflg = {cyc,we,bvalid,rvalid,awready,wready,arready} seen after the edge
    typedef struct {
        logic [5:0]  ctl;
        logic [11:0] awaddr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [11:0] araddr;
        logic [31:0] dat_i;
        logic [6:0]  eflg;
        logic [31:0] e_adr;
        logic [3:0]  e_sel;
        logic [31:0] e_dat;
        logic [1:0]  e_bresp;
        logic [31:0] e_rdata;
        logic [1:0]  e_rresp;
    } vec_t;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
    } wbrec_t;

    vec_t   vecs[15];
    wbrec_t wblog[$];
    logic   auto_ack = 1'b0;
    logic   prev_cyc = 1'b0;
    int     cyc_rises = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge wbs_clk_i);
        #1;
    endtask

    // One cycle with handshake-driven valid release and an optional auto-acking slave.
    task automatic step();
        logic aw_hs, w_hs, ar_hs;
        aw_hs = awvalid && awready;
        w_hs  = wvalid && wready;
        ar_hs = arvalid && arready;
        if (wbm_cyc_o && wbm_ack_i) wblog.push_back('{wbm_we_o, wbm_adr_o, wbm_dat_o});
        tick();
        if (aw_hs) awvalid = 1'b0;
        if (w_hs)  wvalid  = 1'b0;
        if (ar_hs) arvalid = 1'b0;
        if (wbm_cyc_o && !prev_cyc) cyc_rises++;
        prev_cyc = wbm_cyc_o;
        if (auto_ack) wbm_ack_i = wbm_cyc_o;
    endtask

    task automatic do_reset();
        wbs_rst_i = 1'b1;
        tick();
        tick();
        wbs_rst_i = 1'b0;
        tick();
    endtask

    initial begin
        wbs_rst_i = 1'b1;
        {awvalid, wvalid, arvalid, bready, rready, wbm_ack_i} = '0;
        awaddr = '0; araddr = '0; wdata = '0; wstrb = '0; wbm_dat_i = '0;

        vecs[0]  = '{6'b110000, 12'h010, 32'h40, 4'hF, 12'h000, 32'h0,
                     7'b0000000, 32'h0, 4'h0, 32'h0, 2'b00, 32'h0, 2'b00};
        vecs[1]  = '{6'b000000, 12'h000, 32'h0, 4'h0, 12'h000, 32'h0,
                     7'b1100000, 32'h3600_0010, 4'hF, 32'h40, 2'b00, 32'h0, 2'b00};
        vecs[2]  = vecs[1];
        vecs[3]  = '{6'b000001, 12'h000, 32'h0, 4'h0, 12'h000, 32'h0,
                     7'b0010000, 32'h3600_0010, 4'hF, 32'h40, 2'b00, 32'h0, 2'b00};
        vecs[4]  = '{6'b000000, 12'h000, 32'h0, 4'h0, 12'h000, 32'h0,
                     7'b0010000, 32'h3600_0010, 4'hF, 32'h40, 2'b00, 32'h0, 2'b00};
        vecs[5]  = vecs[4];
        vecs[6]  = '{6'b000100, 12'h000, 32'h0, 4'h0, 12'h000, 32'h0,
                     7'b0000111, 32'h3600_0010, 4'hF, 32'h40, 2'b00, 32'h0, 2'b00};
        // stray ack while idle must be ignored
        vecs[7]  = '{6'b000001, 12'h000, 32'h0, 4'h0, 12'h000, 32'h0,
                     7'b0000111, 32'h3600_0010, 4'hF, 32'h40, 2'b00, 32'h0, 2'b00};
        vecs[8]  = '{6'b001000, 12'h000, 32'h0, 4'h0, 12'h084, 32'h0,
                     7'b1000000, 32'h3600_0084, 4'hF, 32'h40, 2'b00, 32'h0, 2'b00};
        vecs[9]  = '{6'b000001, 12'h000, 32'h0, 4'h0, 12'h000, 32'h1234_5678,
                     7'b0001000, 32'h3600_0084, 4'hF, 32'h40, 2'b00, 32'h1234_5678, 2'b00};
        for (int i = 10; i < 14; i++)
            vecs[i] = '{6'b000000, 12'h000, 32'h0, 4'h0, 12'h000, 32'hDEAD_BEEF,
                        7'b0001000, 32'h3600_0084, 4'hF, 32'h40, 2'b00, 32'h1234_5678, 2'b00};
        vecs[14] = '{6'b000010, 12'h000, 32'h0, 4'h0, 12'h000, 32'hDEAD_BEEF,
                     7'b0000111, 32'h3600_0084, 4'hF, 32'h40, 2'b00, 32'h1234_5678, 2'b00};

        // reset state
        tick();
        tick();
        chk("rst_cyc", wbm_cyc_o, 0);
        chk("rst_stb", wbm_stb_o, 0);
        chk("rst_we", wbm_we_o, 0);
        chk("rst_adr", wbm_adr_o, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_awready", awready, 0);
        chk("rst_arready", arready, 0);
        wbs_rst_i = 1'b0;
        tick();
        chk("post_rst_awready", awready, 1);
        chk("post_rst_wready", wready, 1);
        chk("post_rst_arready", arready, 1);

        // vector table: basic write then basic read
        for (int i = 0; i < 15; i++) begin
            {awvalid, wvalid, arvalid, bready, rready, wbm_ack_i} = vecs[i].ctl;
            awaddr = vecs[i].awaddr; wdata = vecs[i].wdata; wstrb = vecs[i].wstrb;
            araddr = vecs[i].araddr; wbm_dat_i = vecs[i].dat_i;
            tick();
            chk($sformatf("v%0d_cyc", i), wbm_cyc_o, vecs[i].eflg[6]);
            chk($sformatf("v%0d_stb", i), wbm_stb_o, vecs[i].eflg[6]);
            chk($sformatf("v%0d_we", i), wbm_we_o, vecs[i].eflg[5]);
            chk($sformatf("v%0d_bvalid", i), bvalid, vecs[i].eflg[4]);
            chk($sformatf("v%0d_rvalid", i), rvalid, vecs[i].eflg[3]);
            chk($sformatf("v%0d_awready", i), awready, vecs[i].eflg[2]);
            chk($sformatf("v%0d_wready", i), wready, vecs[i].eflg[1]);
            chk($sformatf("v%0d_arready", i), arready, vecs[i].eflg[0]);
            chk($sformatf("v%0d_adr", i), wbm_adr_o, vecs[i].e_adr);
            chk($sformatf("v%0d_sel", i), wbm_sel_o, vecs[i].e_sel);
            chk($sformatf("v%0d_dat", i), wbm_dat_o, vecs[i].e_dat);
            chk($sformatf("v%0d_bresp", i), bresp, vecs[i].e_bresp);
            chk($sformatf("v%0d_rdata", i), rdata, vecs[i].e_rdata);
            chk($sformatf("v%0d_rresp", i), rresp, vecs[i].e_rresp);
        end
        {awvalid, wvalid, arvalid, bready, rready, wbm_ack_i} = '0;

        // W three cycles ahead of AW
        wvalid = 1'b1; wdata = 32'hA5A5_A5A5; wstrb = 4'h3;
        step();
        chk("wfirst_wready", wready, 0);
        chk("wfirst_awready", awready, 1);
        chk("wfirst_cyc0", wbm_cyc_o, 0);
        step();
        chk("wfirst_cyc1", wbm_cyc_o, 0);
        step();
        chk("wfirst_cyc2", wbm_cyc_o, 0);
        awvalid = 1'b1; awaddr = 12'h020;
        step();
        chk("wfirst_cyc3", wbm_cyc_o, 0);
        step();
        chk("wfirst_cyc", wbm_cyc_o, 1);
        chk("wfirst_we", wbm_we_o, 1);
        chk("wfirst_adr", wbm_adr_o, 32'h3600_0020);
        chk("wfirst_sel", wbm_sel_o, 4'h3);
        chk("wfirst_dat", wbm_dat_o, 32'hA5A5_A5A5);
        wbm_ack_i = 1'b1;
        step();
        wbm_ack_i = 1'b0;
        chk("wfirst_bvalid", bvalid, 1);
        chk("wfirst_bresp", bresp, 2'b00);
        bready = 1'b1;
        step();
        bready = 1'b0;
        chk("wfirst_bvalid_drop", bvalid, 0);

        // arbitration: held write vs read, twice in a row
        do_reset();
        awvalid = 1'b1; wvalid = 1'b1; awaddr = 12'h030; wdata = 32'h11; wstrb = 4'hF;
        step();
        arvalid = 1'b1; araddr = 12'h040;
        awvalid = 1'b1; wvalid = 1'b1; awaddr = 12'h050; wdata = 32'h22; wstrb = 4'hC;
        chk("arb_arready_low", arready, 0);
        chk("arb_awready_low", awready, 0);
        auto_ack = 1'b1; bready = 1'b1; rready = 1'b1; wbm_dat_i = 32'hCAFE_0040;
        wblog.delete();
        cyc_rises = 0;
        prev_cyc = wbm_cyc_o;
        for (int n = 0; n < 60 && wblog.size() < 3; n++) step();
        repeat (3) step();
        auto_ack = 1'b0; wbm_ack_i = 1'b0; bready = 1'b0; rready = 1'b0;
        chk("arb_count", wblog.size(), 3);
        chk("arb_cyc_rises", cyc_rises, 3);
        if (wblog.size() >= 3) begin
            chk("arb0_we", wblog[0].we, 1);
            chk("arb0_adr", wblog[0].adr, 32'h3600_0030);
            chk("arb0_dat", wblog[0].dat, 32'h11);
            chk("arb1_we", wblog[1].we, 0);
            chk("arb1_adr", wblog[1].adr, 32'h3600_0040);
            chk("arb2_we", wblog[2].we, 1);
            chk("arb2_adr", wblog[2].adr, 32'h3600_0050);
            chk("arb2_dat", wblog[2].dat, 32'h22);
        end
        chk("arb_rdata", rdata, 32'hCAFE_0040);
        chk("arb_idle_awready", awready, 1);
        chk("arb_idle_arready", arready, 1);

        // timeout: cyc/stb high exactly 8 cycles, then SLVERR with zero data
        arvalid = 1'b1; araddr = 12'h0F0;
        step();
        begin
            int n;
            n = 0;
            while (wbm_cyc_o && n < 30) begin
                if (wbm_stb_o) n++;
                step();
            end
            chk("to_stb_cycles", n, 8);
        end
        chk("to_rvalid", rvalid, 1);
        chk("to_rresp", rresp, 2'b10);
        chk("to_rdata", rdata, 32'h0);
        rready = 1'b1;
        step();
        rready = 1'b0;
        chk("to_rvalid_drop", rvalid, 0);

        // ack on the very cycle the timeout would fire wins
        arvalid = 1'b1; araddr = 12'h0F4; wbm_dat_i = 32'h0BAD_F00D;
        step();
        repeat (7) step();
        chk("edge_cyc_still", wbm_cyc_o, 1);
        wbm_ack_i = 1'b1;
        step();
        wbm_ack_i = 1'b0;
        chk("edge_rvalid", rvalid, 1);
        chk("edge_rresp", rresp, 2'b00);
        chk("edge_rdata", rdata, 32'h0BAD_F00D);
        rready = 1'b1;
        step();
        rready = 1'b0;

        // reset in the middle of a Wishbone read
        arvalid = 1'b1; araddr = 12'h100;
        step();
        chk("rstmid_cyc_before", wbm_cyc_o, 1);
        wbs_rst_i = 1'b1;
        step();
        chk("rstmid_cyc", wbm_cyc_o, 0);
        chk("rstmid_stb", wbm_stb_o, 0);
        chk("rstmid_rvalid", rvalid, 0);
        wbs_rst_i = 1'b0;
        step();
        chk("rstmid_arready", arready, 1);
        chk("rstmid_rvalid2", rvalid, 0);
        step();
        chk("rstmid_rvalid3", rvalid, 0);
        chk("rstmid_cyc2", wbm_cyc_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
